nn_layer_sequencer: RTL and testbench
=====================================

Name: nn_layer_sequencer

Overview:
- Top-level phase controller for the single-hidden-layer NN datapath: weight/input load, MAC accumulation of z per neuron, sigmoid activation, back-prop weight update.
- Drives the datapath enables plus the shared index1 (input index) and index2 (neuron index) buses.
- Replaces free-running cycle-count sequencing with an explicit start/busy/done handshake and a datapath stall input.

Parameters:
N_IN, 784, inputs per neuron (index1 range 0..N_IN-1)
N_NEURON, 40, neurons in layer (index2 range 0..N_NEURON-1)
IDX_W, 16, width of index1/index2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin one layer pass; sampled only in IDLE
train  in  1  1: run UPD phase; 0: inference, skip UPD; latched with start
dp_ready  in  1  datapath accepts a beat this cycle; 0 = stall
busy  out  1  high from first cycle after accepted start through DONE
done  out  1  one-cycle pulse in DONE state
phase  out  3  IDLE=0, LOAD=1, MAC=2, ACT=3, UPD=4, DONE=5
index1  out  IDX_W  current input index
index2  out  IDX_W  current neuron index
load_en  out  1  write input/weight word at (index1,index2)
mac_en  out  1  accumulate x[index1]*w[index1][index2]
mac_clr  out  1  first term of neuron: accumulator loads the product instead of adding
z_wr  out  1  last term of neuron: write z[index2]
act_en  out  1  sigmoid on z[index2]
upd_en  out  1  update w[index1][index2]

Behaviour:
- Reset, and every rst-asserted edge, including mid-operation: state IDLE, index1=index2=0, busy=done=0, all enables 0, latched train=0. rst has priority over start.
- IDLE: on an edge with start=1, latch train, go to LOAD with indices 0. start in any other state is ignored.
- Beat rule: a beat is accepted on an edge where state is LOAD/MAC/ACT/UPD and dp_ready=1. Enables are decoded combinationally as (state match) & dp_ready & (index condition). Counters and state advance only on accepted beats. With dp_ready=0, everything holds and all enables are 0.
- LOAD:
  - index1 is the inner counter, index2 the outer; load_en on every beat.
  - After beat (N_IN-1, N_NEURON-1), go to MAC with indices 0.
- MAC:
  - Same index order as LOAD; mac_en on every beat.
  - mac_clr when index1==0; z_wr when index1==N_IN-1. Both coincide with mac_en and both assert if N_IN==1.
  - After beat (N_IN-1, N_NEURON-1), go to ACT.
- ACT:
  - index1 held 0; index2 counts 0..N_NEURON-1; act_en on every beat.
  - After the last beat, go to UPD if train=1, else DONE.
- UPD:
  - index2 is the inner counter, index1 the outer; upd_en on every beat.
  - After beat (N_IN-1, N_NEURON-1), go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE with indices 0. start is not accepted in DONE.
- Wrap: inner counter wraps to 0 and the outer counter increments on the same edge. Both wrap to 0 on phase exit. Indices never exceed N-1.
- Latency with dp_ready held 1, start at edge E0:
  - LOAD and MAC each take N_IN*N_NEURON cycles; ACT takes N_NEURON; UPD takes N_IN*N_NEURON when train=1, else 0; DONE takes 1.
  - Defaults, train=1: done high in cycle 94121 after E0 (31360+31360+40+31360+1).
- phase tracks state; busy = (state != IDLE).

Decomposition:
- Package nn_seq_pkg: state/phase enum codes (3 bits, values above) and default N_IN/N_NEURON/IDX_W constants.
- One sub-module, nn_idx_counter: 2-D nested counter with an inner-select input (index1 or index2 inner), advance, clear, and last_inner/last_all flags. The FSM instantiates one copy and reprograms inner-select per phase.

Test Plan:
- N_IN=4, N_NEURON=3, train=1, dp_ready=1, start pulse:
  - 12 load_en beats, (index1,index2) in order (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2).
  - 12 mac_en beats: mac_clr at index1=0, z_wr at index1=3, exactly 3 of each.
  - 3 act_en beats, index2=0,1,2.
  - 12 upd_en beats in order (0,0),(0,1),(0,2),(1,0)...(3,2).
  - done pulse at cycle 40 after start, then phase=0.
- Same with train=0 -> no upd_en; done at cycle 28 after start.
- dp_ready pseudo-random 50% -> enable sequence identical to the previous case minus stall cycles; no enable while dp_ready=0. Stall on the final MAC beat holds phase=2 until accepted.
- rst asserted during MAC at (index1=2,index2=1) -> next cycle phase=0, indices 0, all outputs 0. A later start runs a full pass from LOAD (0,0).
- start held high continuously -> only one pass begins per IDLE entry. start during busy ignored; start and rst together -> stays IDLE.
- Default params, dp_ready=1, train=1 -> phase transitions at cycles 31360, 62720, 62760, 94120 after E0; done in cycle 94121.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// Shared definitions for the NN layer sequencer: phase codes, counter ordering
// selector and default layer dimensions.
package nn_seq_pkg;

    localparam int DEF_N_IN     = 784;
    localparam int DEF_N_NEURON = 40;
    localparam int DEF_IDX_W    = 16;

    // Encodings double as the externally visible phase code.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MAC  = 3'd2,
        ST_ACT  = 3'd3,
        ST_UPD  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    typedef enum logic {
        SEL_IDX1_INNER = 1'b0,
        SEL_IDX2_INNER = 1'b1
    } inner_sel_e;

endpackage

// File: rtl/nn_idx_counter.sv
// Two-dimensional nested index counter; either index can be the inner
// (fast) dimension, chosen per cycle by inner_sel.
module nn_idx_counter
    import nn_seq_pkg::*;
#(
    parameter int N_IN     = DEF_N_IN,
    parameter int N_NEURON = DEF_N_NEURON,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  inner_sel_e       inner_sel,
    input  logic             advance,
    input  logic             clear,
    output logic [IDX_W-1:0] index1,
    output logic [IDX_W-1:0] index2,
    output logic             last_inner,
    output logic             last_all
);

    localparam logic [IDX_W-1:0] LAST1 = IDX_W'(N_IN - 1);
    localparam logic [IDX_W-1:0] LAST2 = IDX_W'(N_NEURON - 1);

    logic last1;
    logic last2;

    assign last1      = (index1 == LAST1);
    assign last2      = (index2 == LAST2);
    assign last_all   = last1 & last2;
    assign last_inner = (inner_sel == SEL_IDX1_INNER) ? last1 : last2;

    // clear wins over advance so a phase exit always lands on (0,0).
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            index1 <= '0;
            index2 <= '0;
        end else if (advance) begin
            if (inner_sel == SEL_IDX1_INNER) begin
                if (last1) begin
                    index1 <= '0;
                    index2 <= last2 ? '0 : index2 + 1'b1;
                end else begin
                    index1 <= index1 + 1'b1;
                end
            end else begin
                if (last2) begin
                    index2 <= '0;
                    index1 <= last1 ? '0 : index1 + 1'b1;
                end else begin
                    index2 <= index2 + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Phase controller for the single-hidden-layer NN datapath: sequences
// LOAD, MAC, ACT and optional UPD passes over the shared index buses.
module nn_layer_sequencer
    import nn_seq_pkg::*;
#(
    parameter int N_IN     = DEF_N_IN,
    parameter int N_NEURON = DEF_N_NEURON,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             train,
    input  logic             dp_ready,
    output logic             busy,
    output logic             done,
    output logic [2:0]       phase,
    output logic [IDX_W-1:0] index1,
    output logic [IDX_W-1:0] index2,
    output logic             load_en,
    output logic             mac_en,
    output logic             mac_clr,
    output logic             z_wr,
    output logic             act_en,
    output logic             upd_en
);

    // Handshake: in LOAD/MAC/ACT/UPD the sequencer always offers a beat; the
    // beat transfers on a clock edge where dp_ready=1. Enables are asserted
    // only in that cycle, and indices/state move only on a transferred beat.

    state_e     state;
    state_e     state_n;
    logic       train_q;
    inner_sel_e inner_sel;
    logic       advance;
    logic       clear;
    logic       last_inner;
    logic       last_all;

    nn_idx_counter #(
        .N_IN     (N_IN),
        .N_NEURON (N_NEURON),
        .IDX_W    (IDX_W)
    ) u_idx (
        .clk        (clk),
        .rst        (rst),
        .inner_sel  (inner_sel),
        .advance    (advance),
        .clear      (clear),
        .index1     (index1),
        .index2     (index2),
        .last_inner (last_inner),
        .last_all   (last_all)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            train_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && start) begin
                train_q <= train;
            end
        end
    end

    always_comb begin
        state_n   = state;
        inner_sel = SEL_IDX1_INNER;
        advance   = 1'b0;
        clear     = 1'b0;
        load_en   = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        z_wr      = 1'b0;
        act_en    = 1'b0;
        upd_en    = 1'b0;

        case (state)
            ST_IDLE: begin
                clear = 1'b1;
                if (start) begin
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (dp_ready) begin
                    load_en = 1'b1;
                    advance = 1'b1;
                    if (last_all) begin
                        clear   = 1'b1;
                        state_n = ST_MAC;
                    end
                end
            end
            ST_MAC: begin
                if (dp_ready) begin
                    mac_en  = 1'b1;
                    mac_clr = (index1 == '0);
                    z_wr    = last_inner;
                    advance = 1'b1;
                    if (last_all) begin
                        clear   = 1'b1;
                        state_n = ST_ACT;
                    end
                end
            end
            ST_ACT: begin
                // index1 stays 0 because the pass ends before index2 wraps.
                inner_sel = SEL_IDX2_INNER;
                if (dp_ready) begin
                    act_en  = 1'b1;
                    advance = 1'b1;
                    if (last_inner) begin
                        clear   = 1'b1;
                        state_n = train_q ? ST_UPD : ST_DONE;
                    end
                end
            end
            ST_UPD: begin
                inner_sel = SEL_IDX2_INNER;
                if (dp_ready) begin
                    upd_en  = 1'b1;
                    advance = 1'b1;
                    if (last_all) begin
                        clear   = 1'b1;
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                clear   = 1'b1;
                state_n = ST_IDLE;
            end
            default: begin
                clear   = 1'b1;
                state_n = ST_IDLE;
            end
        endcase
    end

    assign phase = state;
    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer: a small-dimension instance for
// sequence checks plus a default-dimension instance for full-size timing.
module tb_nn_layer_sequencer;

    localparam int NI    = 4;
    localparam int NN    = 3;
    localparam int W     = 16;
    localparam int NI_D  = 784;
    localparam int NN_D  = 40;
    localparam int BEAT_W = 38;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, train, dp_ready;
    logic busy, done, load_en, mac_en, mac_clr, z_wr, act_en, upd_en;
    logic [2:0]   phase;
    logic [W-1:0] index1, index2;

    logic rst_b, start_b;
    logic busy_b, done_b, load_en_b, mac_en_b, mac_clr_b, z_wr_b, act_en_b, upd_en_b;
    logic [2:0]   phase_b;
    logic [W-1:0] index1_b, index2_b;

    nn_layer_sequencer #(.N_IN(NI), .N_NEURON(NN), .IDX_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .train(train), .dp_ready(dp_ready),
        .busy(busy), .done(done), .phase(phase), .index1(index1), .index2(index2),
        .load_en(load_en), .mac_en(mac_en), .mac_clr(mac_clr), .z_wr(z_wr),
        .act_en(act_en), .upd_en(upd_en)
    );

    nn_layer_sequencer dut_big (
        .clk(clk), .rst(rst_b), .start(start_b), .train(1'b1), .dp_ready(1'b1),
        .busy(busy_b), .done(done_b), .phase(phase_b), .index1(index1_b), .index2(index2_b),
        .load_en(load_en_b), .mac_en(mac_en_b), .mac_clr(mac_clr_b), .z_wr(z_wr_b),
        .act_en(act_en_b), .upd_en(upd_en_b)
    );

    int checks = 0;
    int errors = 0;
    logic [BEAT_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Beat word: {load,mac,act,upd}, mac_clr, z_wr, index1, index2.
    function automatic logic [BEAT_W-1:0] beat(input logic [3:0] en, input logic clr,
                                               input logic zw, input int i1, input int i2);
        return {en, clr, zw, 16'(i1), 16'(i2)};
    endfunction

    // Reference model: the beat order of one whole pass.
    task automatic push_pass(input logic tr);
        for (int n = 0; n < NN; n++)
            for (int i = 0; i < NI; i++)
                exp_q.push_back(beat(4'b1000, 1'b0, 1'b0, i, n));
        for (int n = 0; n < NN; n++)
            for (int i = 0; i < NI; i++)
                exp_q.push_back(beat(4'b0100, i == 0, i == NI - 1, i, n));
        for (int n = 0; n < NN; n++)
            exp_q.push_back(beat(4'b0010, 1'b0, 1'b0, 0, n));
        if (tr)
            for (int i = 0; i < NI; i++)
                for (int n = 0; n < NN; n++)
                    exp_q.push_back(beat(4'b0001, 1'b0, 1'b0, i, n));
    endtask

    // Monitor: samples at negedge, when inputs for the next edge are settled.
    initial begin
        logic [BEAT_W-1:0] act_w;
        logic [BEAT_W-1:0] exp_w;
        forever begin
            @(negedge clk);
            if (load_en | mac_en | act_en | upd_en | mac_clr | z_wr) begin
                act_w = {load_en, mac_en, act_en, upd_en, mac_clr, z_wr, index1, index2};
                if (!dp_ready) begin
                    chk("enable_during_stall", 64'(act_w), 64'(0));
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(act_w), 64'(0));
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("beat", 64'(act_w), 64'(exp_w));
                end
            end
        end
    end

    task automatic wait_done(input logic rnd, output int dc);
        int   e;
        logic stalled;
        logic hold_chk;
        e = 0;
        dc = -1;
        stalled = 1'b0;
        while (e < 2000) begin
            hold_chk = 1'b0;
            if (rnd && !stalled && phase == 3'd2 && index1 == W'(NI - 1) && index2 == W'(NN - 1)) begin
                dp_ready = 1'b0;
                stalled  = 1'b1;
                hold_chk = 1'b1;
            end else if (rnd) begin
                dp_ready = 1'($urandom_range(0, 1));
            end else begin
                dp_ready = 1'b1;
            end
            @(posedge clk); #1;
            e++;
            if (hold_chk) begin
                chk("final_mac_stall_phase", 64'(phase), 64'(2));
                chk("final_mac_stall_index1", 64'(index1), 64'(NI - 1));
            end
            if (done) begin
                dc = e + 1;
                break;
            end
        end
        if (dc < 0) chk("done_timeout", 64'(0), 64'(1));
        if (rnd) chk("final_mac_stall_seen", 64'(stalled), 64'(1));
    endtask

    task automatic run_pass(input logic tr, input logic rnd, output int dc);
        start = 1'b1;
        train = tr;
        dp_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        train = ~tr;
        wait_done(rnd, dc);
        @(posedge clk); #1;
        chk("idle_after_done", 64'({phase, done, busy}), 64'(0));
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic small_tests();
        int   dc;
        logic found;

        push_pass(1'b1);
        run_pass(1'b1, 1'b0, dc);
        chk("done_cycle_train", 64'(dc), 64'(40));

        push_pass(1'b0);
        run_pass(1'b0, 1'b0, dc);
        chk("done_cycle_infer", 64'(dc), 64'(28));

        push_pass(1'b0);
        run_pass(1'b0, 1'b1, dc);

        // Reset in the middle of MAC.
        push_pass(1'b1);
        start = 1'b1; train = 1'b1; dp_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (phase == 3'd2 && index1 == W'(2) && index2 == W'(1)) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("reach_mac_2_1", 64'(found), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        chk("mid_reset_ctrl", 64'({phase, busy, done, load_en, mac_en, mac_clr, z_wr, act_en, upd_en}), 64'(0));
        chk("mid_reset_index", 64'({index1, index2}), 64'(0));
        rst = 1'b0;
        push_pass(1'b1);
        run_pass(1'b1, 1'b0, dc);
        chk("done_cycle_after_reset", 64'(dc), 64'(40));

        // start held high: exactly one pass per IDLE entry.
        push_pass(1'b0);
        push_pass(1'b0);
        start = 1'b1; train = 1'b0; dp_ready = 1'b1;
        @(posedge clk); #1;
        wait_done(1'b0, dc);
        chk("done_cycle_held_start", 64'(dc), 64'(28));
        @(posedge clk); #1;
        chk("held_start_idle", 64'(phase), 64'(0));
        @(posedge clk); #1;
        chk("held_start_restart", 64'(phase), 64'(1));
        start = 1'b0;
        wait_done(1'b0, dc);
        repeat (3) begin
            @(posedge clk); #1;
            chk("held_start_stays_idle", 64'(phase), 64'(0));
        end
        chk("queue_drained_held", 64'(exp_q.size()), 64'(0));

        // start together with rst stays in IDLE.
        start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        chk("start_rst_idle", 64'({phase, busy}), 64'(0));
        @(posedge clk); #1;
        chk("start_rst_still_idle", 64'(phase), 64'(0));
    endtask

    task automatic big_test();
        int e;
        int dcyc;
        int prev;
        int trans[$];
        int exp_t[4];
        exp_t[0] = NI_D * NN_D;
        exp_t[1] = 2 * NI_D * NN_D;
        exp_t[2] = 2 * NI_D * NN_D + NN_D;
        exp_t[3] = 3 * NI_D * NN_D + NN_D;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        chk("big_load_entry", 64'(phase_b), 64'(1));
        prev = int'(phase_b);
        e = 0;
        dcyc = -1;
        while (e < 95000) begin
            @(posedge clk); #1;
            e++;
            if (int'(phase_b) != prev) begin
                trans.push_back(e);
                prev = int'(phase_b);
            end
            if (done_b) begin
                dcyc = e + 1;
                break;
            end
        end
        chk("big_transition_count", 64'(trans.size()), 64'(4));
        for (int k = 0; k < 4; k++)
            if (k < trans.size()) chk("big_transition_edge", 64'(trans[k]), 64'(exp_t[k]));
        chk("big_done_cycle", 64'(dcyc), 64'(3 * NI_D * NN_D + NN_D + 1));
        @(posedge clk); #1;
        chk("big_idle_after_done", 64'({phase_b, busy_b}), 64'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; train = 1'b0; dp_ready = 1'b0;
        rst_b = 1'b1; start_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 64'({phase, busy, done, load_en, mac_en, mac_clr, z_wr, act_en, upd_en}), 64'(0));
        chk("reset_index", 64'({index1, index2}), 64'(0));
        rst = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;
        chk("idle_without_start", 64'(phase), 64'(0));
        fork
            big_test();
            small_tests();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
